// File: rtl/axi_pkg.sv
// Shared AXI datapath types used across the DMA engine and its stream adapters.
package axi_pkg;

    typedef logic [63:0] addr_64_t;

    typedef struct packed {
        addr_64_t    addr;
        logic [31:0] len;
    } trans_64_t;

    typedef logic [15:0] elem16_t;

endpackage

// File: rtl/axis_mm2s_unpacker_pkg.sv
// Local types for the MM2S width down-converter.
package axis_mm2s_unpacker_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } unpack_state_e;

endpackage

// File: rtl/axis_util_pkg.sv
// Stream helpers shared by the MM2S unpacker and the S2MM packer.
package axis_util_pkg;

    // Keeps wider than this are not supported by keep_last_idx.
    localparam int KEEP_MAX_W = 64;
    localparam int KEEP_IDX_W = $clog2(KEEP_MAX_W);

    typedef struct packed {
        logic [KEEP_IDX_W-1:0] idx;
        logic                  legal;
    } keep_info_t;

    // idx is the highest set bit; legal means non-zero and contiguous from bit 0.
    function automatic keep_info_t keep_last_idx(input logic [KEEP_MAX_W-1:0] keep);
        keep_info_t info;
        info.idx = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            if (keep[i]) begin
                info.idx = i[KEEP_IDX_W-1:0];
            end
        end
        info.legal = (keep != '0) &&
                     ((keep & (keep + {{(KEEP_MAX_W-1){1'b0}}, 1'b1})) == '0);
        return info;
    endfunction

endpackage

// File: rtl/axis_mm2s_unpacker_if.sv
// Wide MM2S input stream plus narrow element output stream of the unpacker.
interface axis_mm2s_unpacker_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ELEM_WIDTH = 16
);
    localparam int NUM_ELEMS = DATA_WIDTH / ELEM_WIDTH;

    // Both streams: a transfer happens on a rising clk edge where tvalid && tready.
    // tvalid must not wait on tready, and payload stays stable while tvalid && !tready.
    logic [DATA_WIDTH-1:0] s_tdata;
    logic [NUM_ELEMS-1:0]  s_tkeep;
    logic                  s_tlast;
    logic                  s_tvalid;
    logic                  s_tready;

    logic [ELEM_WIDTH-1:0] m_tdata;
    logic                  m_tlast;
    logic                  m_tvalid;
    logic                  m_tready;

    // slave is the unpacker; master is the DMA source plus accelerator sink around it.
    modport slave (
        input  s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tlast, m_tvalid
    );

    modport master (
        output s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tlast, m_tvalid
    );

endinterface

// File: rtl/axis_mm2s_unpacker.sv
// Holds one MM2S beat and replays it as ELEM_WIDTH elements, LSB element first,
// trimming the final beat to its keep and carrying tlast to the last element.
module axis_mm2s_unpacker
    import axi_pkg::*;
    import axis_util_pkg::*;
    import axis_mm2s_unpacker_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ELEM_WIDTH = $bits(elem16_t)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    axis_mm2s_unpacker_if.slave        bus,
    output logic [31:0]                elem_count,
    output logic                       pkt_done,
    output logic                       err_keep,
    output unpack_state_e              dbg_state_o
);

    localparam int NUM_ELEMS = DATA_WIDTH / ELEM_WIDTH;
    localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_FULL = idx_t'(NUM_ELEMS - 1);

    unpack_state_e                        state_q, state_d;
    logic [NUM_ELEMS-1:0][ELEM_WIDTH-1:0] beat_q, beat_d;
    idx_t                                 idx_q, idx_d;
    idx_t                                 last_idx_q, last_idx_d;
    logic                                 beat_last_q, beat_last_d;
    logic [31:0]                          count_q, count_d;
    logic                                 pkt_done_q, pkt_done_d;
    logic                                 err_q, err_d;

    logic                                 full;
    logic                                 at_last;
    logic                                 m_hs;
    logic                                 s_ready;
    logic                                 s_hs;
    logic [KEEP_MAX_W-1:0]                keep_ext;
    keep_info_t                           keep_info;
    logic                                 keep_bad;
    idx_t                                 load_last_idx;

    assign full    = (state_q == ST_FULL);
    assign at_last = (idx_q == last_idx_q);
    assign m_hs    = full && bus.m_tready;
    // Reload in the same cycle the last element leaves, so a steady stream has no bubble.
    assign s_ready = !rst && !clear && (!full || (bus.m_tready && at_last));
    assign s_hs    = bus.s_tvalid && s_ready;

    always_comb begin
        keep_ext                  = '0;
        keep_ext[NUM_ELEMS-1:0]   = bus.s_tkeep;
        keep_info                 = keep_last_idx(keep_ext);
        keep_bad                  = bus.s_tlast && !keep_info.legal;
        load_last_idx             = LAST_FULL;
        // Keep is only meaningful on a last beat; an illegal one plays the whole beat.
        if (bus.s_tlast && keep_info.legal) begin
            load_last_idx = idx_t'(keep_info.idx);
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        idx_d       = idx_q;
        last_idx_d  = last_idx_q;
        beat_last_d = beat_last_q;
        count_d     = count_q;
        pkt_done_d  = 1'b0;
        err_d       = err_q;

        if (m_hs) begin
            count_d    = count_q + 32'd1;
            pkt_done_d = beat_last_q && at_last;
            if (at_last) begin
                state_d = ST_EMPTY;
            end else begin
                idx_d = idx_q + idx_t'(1);
            end
        end

        if (s_hs) begin
            state_d     = ST_FULL;
            beat_d      = bus.s_tdata;
            idx_d       = '0;
            last_idx_d  = load_last_idx;
            beat_last_d = bus.s_tlast;
            err_d       = err_q || keep_bad;
        end

        // Flush wins over both handshakes of the same cycle.
        if (clear) begin
            state_d    = ST_EMPTY;
            idx_d      = '0;
            count_d    = '0;
            pkt_done_d = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            beat_q      <= '0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            beat_last_q <= 1'b0;
            count_q     <= '0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            idx_q       <= idx_d;
            last_idx_q  <= last_idx_d;
            beat_last_q <= beat_last_d;
            count_q     <= count_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.s_tready = s_ready;
    assign bus.m_tvalid = full;
    assign bus.m_tdata  = full ? beat_q[idx_q] : '0;
    assign bus.m_tlast  = full && beat_last_q && at_last;

    assign elem_count   = count_q;
    assign pkt_done     = pkt_done_q;
    assign err_keep     = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_axis_mm2s_unpacker.sv
// Bench for axis_mm2s_unpacker: queue-based element model checked every cycle,
// plus literal expectations for the streaming, stall, keep, clear and reset cases.
module tb_axis_mm2s_unpacker;
    import axi_pkg::*;
    import axis_mm2s_unpacker_pkg::*;

    localparam int DW = 256;
    localparam int EW = 16;
    localparam int NE = DW / EW;

    logic          clk;
    logic          rst;
    logic          clear;
    logic [31:0]   elem_count;
    logic          pkt_done;
    logic          err_keep;
    unpack_state_e dbg_state;

    axis_mm2s_unpacker_if #(.DATA_WIDTH(DW), .ELEM_WIDTH(EW)) bus ();

    axis_mm2s_unpacker #(.DATA_WIDTH(DW), .ELEM_WIDTH(EW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .bus         (bus),
        .elem_count  (elem_count),
        .pkt_done    (pkt_done),
        .err_keep    (err_keep),
        .dbg_state_o (dbg_state)
    );

    int          nchk = 0;
    int          nerr = 0;
    logic [EW:0] exp_q[$];     // {last, data} still owed by the DUT
    logic [EW:0] log_q[$];     // {last, data} as emitted by the DUT
    int          hs_cyc_q[$];  // cycle of each logged element handshake
    int          s_cyc_q[$];   // cycle of each beat handshake
    int          cyc = 0;
    int          mcount = 0;
    logic        mpkt = 1'b0;
    logic        merr = 1'b0;
    int          pkt_pulses = 0;
    logic        stall_prev = 1'b0;
    logic [EW:0] stall_val = '0;
    int          mode = 0;
    int          ph = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, otherwise random.
    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: bus.m_tready = 1'b1;
                1: begin
                    bus.m_tready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
                default: bus.m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model and compare, sampled on the falling edge while all inputs are settled.
    always @(negedge clk) begin : monitor
        int          c;
        int          n;
        logic        legal;
        logic [EW:0] front;
        logic        exp_sready;
        cyc++;
        if (rst) begin
            check("rst_m_tvalid", bus.m_tvalid, 1'b0);
            check("rst_m_tlast", bus.m_tlast, 1'b0);
            check("rst_m_tdata", bus.m_tdata, '0);
            check("rst_s_tready", bus.s_tready, 1'b0);
            check("rst_elem_count", elem_count, '0);
            check("rst_pkt_done", pkt_done, 1'b0);
            check("rst_err_keep", err_keep, 1'b0);
            exp_q.delete();
            mcount     = 0;
            mpkt       = 1'b0;
            merr       = 1'b0;
            stall_prev = 1'b0;
        end else begin
            front      = (exp_q.size() != 0) ? exp_q[0] : '0;
            exp_sready = !clear && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.m_tready));
            check("s_tready", bus.s_tready, exp_sready);
            check("m_tvalid", bus.m_tvalid, exp_q.size() != 0);
            check("m_tdata", bus.m_tdata, front[EW-1:0]);
            check("m_tlast", bus.m_tlast, front[EW]);
            check("state_full", dbg_state == ST_FULL, exp_q.size() != 0);
            check("elem_count", elem_count, 32'(mcount));
            check("pkt_done", pkt_done, mpkt);
            check("err_keep", err_keep, merr);
            if (stall_prev) begin
                check("stall_hold", {bus.m_tlast, bus.m_tdata}, stall_val);
            end
            if (pkt_done) pkt_pulses++;
            stall_prev = bus.m_tvalid && !bus.m_tready && !clear;
            stall_val  = {bus.m_tlast, bus.m_tdata};

            if (clear) begin
                exp_q.delete();
                mcount     = 0;
                mpkt       = 1'b0;
                merr       = 1'b0;
                stall_prev = 1'b0;
            end else begin
                mpkt = 1'b0;
                if (bus.m_tvalid && bus.m_tready) begin
                    log_q.push_back({bus.m_tlast, bus.m_tdata});
                    hs_cyc_q.push_back(cyc);
                end
                if (bus.m_tready && exp_q.size() != 0) begin
                    front = exp_q.pop_front();
                    mcount++;
                    mpkt = front[EW];
                end
                if (bus.s_tvalid && bus.s_tready) begin
                    s_cyc_q.push_back(cyc);
                    c     = $countones(bus.s_tkeep);
                    legal = (c > 0) && (32'(bus.s_tkeep) == ((32'd1 << c) - 32'd1));
                    n     = (bus.s_tlast && legal) ? c : NE;
                    if (bus.s_tlast && !legal) merr = 1'b1;
                    for (int j = 0; j < n; j++) begin
                        exp_q.push_back({bus.s_tlast && (j == n - 1), bus.s_tdata[j*EW +: EW]});
                    end
                end
            end
        end
    end

    task automatic send_beat(input int k, input logic last, input logic [NE-1:0] keep);
        int   budget;
        logic hs;
        for (int j = 0; j < NE; j++) begin
            bus.s_tdata[j*EW +: EW] = elem16_t'((k << 8) | j);
        end
        bus.s_tkeep  = keep;
        bus.s_tlast  = last;
        bus.s_tvalid = 1'b1;
        hs           = 1'b0;
        budget       = 0;
        while (!hs && budget < 200) begin
            @(negedge clk);
            hs = bus.s_tready;
            @(posedge clk);
            #1;
            budget++;
        end
        bus.s_tvalid = 1'b0;
        check("beat_accepted", hs, 1'b1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || bus.m_tvalid) && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain", (exp_q.size() == 0) && !bus.m_tvalid, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n);
        int budget;
        budget = 0;
        while (log_q.size() < n && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("wait_log", log_q.size() >= n, 1'b1);
    endtask

    task automatic start_scn(input int m);
        mode  = m;
        ph    = 0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        log_q.delete();
        hs_cyc_q.delete();
        s_cyc_q.delete();
        pkt_pulses = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NE-1:0] keep;
        logic          last;
        int            nlog;
        rst          = 1'b0;
        clear        = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tlast  = 1'b0;
        bus.s_tvalid = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("init_s_tready_in_rst", bus.s_tready, 1'b0);
        check("init_m_tvalid", bus.m_tvalid, 1'b0);
        rst = 1'b0;
        #1;
        check("init_s_tready_empty", bus.s_tready, 1'b1);
        check("init_elem_count", elem_count, 32'd0);
        @(posedge clk);
        #1;

        // Streaming: 4 beats, back to back, full keep.
        start_scn(0);
        for (int k = 0; k < 4; k++) send_beat(k, k == 3, '1);
        wait_idle();
        check("stream_count", elem_count, 32'd64);
        check("stream_logged", log_q.size(), 64);
        check("stream_first", log_q[0], {1'b0, 16'h0000});
        check("stream_beat1", log_q[16], {1'b0, 16'h0100});
        check("stream_lastpre", log_q[62], {1'b0, 16'h030E});
        check("stream_last", log_q[63], {1'b1, 16'h030F});
        check("stream_latency", hs_cyc_q[0] - s_cyc_q[0], 1);
        check("stream_no_gaps", hs_cyc_q[63] - hs_cyc_q[0], 63);
        check("stream_pkt_pulses", pkt_pulses, 1);

        // Backpressure: ready pattern 1,0,0,1 over two beats.
        start_scn(1);
        send_beat(0, 1'b0, '1);
        send_beat(1, 1'b1, '1);
        wait_idle();
        check("bp_count", elem_count, 32'd32);
        check("bp_beats", s_cyc_q.size(), 2);
        check("bp_e15", log_q[15], {1'b0, 16'h000F});
        check("bp_last", log_q[31], {1'b1, 16'h010F});
        check("bp_pkt_pulses", pkt_pulses, 1);

        // Partial last beat followed immediately by another transfer.
        start_scn(0);
        send_beat(0, 1'b1, 16'h0007);
        send_beat(1, 1'b1, 16'hFFFF);
        wait_idle();
        check("part_logged", log_q.size(), 19);
        check("part_e1", log_q[1], {1'b0, 16'h0001});
        check("part_e2", log_q[2], {1'b1, 16'h0002});
        check("part_next", log_q[3], {1'b0, 16'h0100});
        check("part_no_bubble", hs_cyc_q[3] - hs_cyc_q[2], 1);
        check("part_reload_cycle", s_cyc_q[1] - s_cyc_q[0], 3);
        check("part_err", err_keep, 1'b0);
        check("part_pkt_pulses", pkt_pulses, 2);

        // Illegal keeps: non-contiguous then all-zero; both play full beats.
        start_scn(0);
        send_beat(0, 1'b1, 16'h0005);
        send_beat(1, 1'b1, 16'h0000);
        wait_idle();
        check("bad_logged", log_q.size(), 32);
        check("bad_e14", log_q[14], {1'b0, 16'h000E});
        check("bad_e15", log_q[15], {1'b1, 16'h000F});
        check("bad_e31", log_q[31], {1'b1, 16'h010F});
        check("bad_err", err_keep, 1'b1);
        send_beat(2, 1'b1, '1);
        wait_idle();
        check("bad_err_sticky", err_keep, 1'b1);

        // Clear after element 5 of beat 0, then restart.
        start_scn(0);
        send_beat(0, 1'b1, '1);
        wait_log(6);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_m_tvalid", bus.m_tvalid, 1'b0);
        check("clr_count", elem_count, 32'd0);
        check("clr_err", err_keep, 1'b0);
        nlog = log_q.size();
        check("clr_logged", nlog, 6);
        send_beat(1, 1'b1, '1);
        wait_idle();
        check("clr_restart", log_q[6], {1'b0, 16'h0100});
        check("clr_restart_count", elem_count, 32'd16);
        check("clr_pkt_pulses", pkt_pulses, 1);

        // Asynchronous reset between edges while a beat is half played.
        start_scn(0);
        send_beat(0, 1'b1, '1);
        wait_log(4);
        #1;
        rst = 1'b1;
        #1;
        check("arst_m_tvalid", bus.m_tvalid, 1'b0);
        check("arst_m_tlast", bus.m_tlast, 1'b0);
        check("arst_m_tdata", bus.m_tdata, '0);
        check("arst_s_tready", bus.s_tready, 1'b0);
        check("arst_count", elem_count, 32'd0);
        check("arst_pkt_done", pkt_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("arst_no_more_elems", log_q.size(), 4);
        check("arst_no_pkt", pkt_pulses, 0);
        check("arst_idle", bus.m_tvalid, 1'b0);

        // Random beats, gaps, keeps and downstream ready.
        start_scn(2);
        for (int b = 0; b < 40; b++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            last = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       keep = '1;
                1:       keep = NE'((32'd1 << $urandom_range(1, NE)) - 32'd1);
                2:       keep = NE'($urandom);
                default: keep = '0;
            endcase
            send_beat(b, last, keep);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/axis_mm2s_unpacker.md
# axis_mm2s_unpacker

Width down-converter that sits directly downstream of the DMA MM2S stream port and feeds the accelerator input. It accepts DATA_WIDTH-bit beats, holds one beat, and emits it as a stream of ELEM_WIDTH-bit elements, least-significant element first. On the final beat it honours element-granular keep, and it carries tlast through to the last emitted element. It keeps an element counter and a sticky protocol-error flag for bring-up and bench checking.

## Interface
Parameters:
- DATA_WIDTH, 256, MM2S beat width; must be an integer multiple of ELEM_WIDTH
- ELEM_WIDTH, 16, element width delivered to the accelerator
- NUM_ELEMS, DATA_WIDTH/ELEM_WIDTH (derived localparam), elements per beat

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- clear  in  1  synchronous flush: drop the held beat, zero the counters, clear the error flag
- s_tdata  in  DATA_WIDTH  MM2S beat
- s_tkeep  in  NUM_ELEMS  per-element valid; examined only when s_tlast=1
- s_tlast  in  1  last beat of the transfer
- s_tvalid  in  1  beat valid
- s_tready  out  1  beat accepted
- m_tdata  out  ELEM_WIDTH  element
- m_tlast  out  1  last element of the transfer
- m_tvalid  out  1  element valid
- m_tready  in  1  downstream ready
- elem_count  out  32  elements handshaked on m_* since reset or clear
- pkt_done  out  1  one-cycle pulse on the m_tlast handshake
- err_keep  out  1  sticky flag for an illegal tkeep on a last beat

## Operation
- State machine with two states:
  - EMPTY: no beat held.
  - FULL: a beat is held in buf, with element index idx and last index last_idx.
- EMPTY to FULL on an s handshake. The block latches:
  - buf = s_tdata
  - idx = 0
  - buf_last = s_tlast
  - last_idx = NUM_ELEMS-1 if s_tlast=0. If s_tlast=1, last_idx = (index of the highest set bit of s_tkeep).
- Legal keep on a last beat is contiguous from bit 0. A non-contiguous or all-zero keep sets err_keep. In that case the beat is treated as full (last_idx=NUM_ELEMS-1).
- Output path in FULL:
  - m_tdata = buf[idx*ELEM_WIDTH +: ELEM_WIDTH]
  - m_tvalid = 1
  - m_tlast = buf_last && (idx==last_idx)
- On an m handshake with idx<last_idx: idx increments.
- On an m handshake with idx==last_idx:
  - If a new s handshake occurs in the same cycle, reload from s_* and stay FULL.
  - Otherwise go to EMPTY.
- s_tready = !rst && !clear && (EMPTY || (m_tready && idx==last_idx)). It depends combinationally on m_tready; this is intentional and gives full throughput.
- elem_count increments by 1 per m handshake and wraps modulo 2^32.
- pkt_done = registered (m_tvalid && m_tready && m_tlast).
- clear has priority over every handshake in the same cycle. That cycle's s and m handshakes are not counted, and the state becomes EMPTY.

## Timing
- Reset values: state EMPTY, m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0 while rst is high, elem_count=0, pkt_done=0, err_keep=0.
- Latency: an s handshake in cycle N gives m_tvalid=1 in cycle N+1 with element 0.
- Throughput with m_tready held at 1 and s_tvalid held at 1: one element per cycle, no bubbles, and one beat accepted every NUM_ELEMS cycles.
- m_tdata and m_tlast are stable while m_tvalid && !m_tready (AXIS rule). m_tvalid never drops without a handshake, except on clear or rst.
- NUM_ELEMS==1: the block behaves as a one-stage register slice, and s_tready = EMPTY || m_tready.
- A last beat with keep=...0001 emits exactly one element, with m_tlast=1.
- Assertion of rst mid-transfer drops the held beat immediately; no partial tlast is generated.

## Structure
- Single module; no sub-module.
- Put the function `keep_last_idx(keep) -> {idx, legal}` in a shared package `axis_util_pkg`, for reuse by the future S2MM packer.
- Put `elem16_t` (logic [15:0]) in `axi_pkg` next to `addr_64_t`/`trans_64_t`. Derived widths (NUM_ELEMS, $clog2 index width) stay local.

## Test plan
All scenarios use DATA_WIDTH=256, ELEM_WIDTH=16, and beat k with element j = (k<<8)|j.
- Streaming: 4 beats, tlast on beat 3, keep all ones, m_tready=1 -> 64 elements 0x0000..0x030F in order, no gaps, m_tlast only on 0x030F, pkt_done pulses once, elem_count=64.
- Backpressure: m_tready toggles 1,0,0,1 repeating over 2 beats -> data holds stable while stalled, s_tready high only in the cycle element 15 is taken, elem_count=32.
- Partial last: last beat keep=0x0007 -> 3 elements from that beat, m_tlast on element 2, next beat accepted the following cycle, err_keep=0.
- Bad keep: last beat keep=0x0005, then a new transfer with keep=0x0000 -> err_keep=1 sticky, each beat emits 16 elements with m_tlast on element 15.
- Clear mid-beat: clear pulsed after element 5 of beat 0 -> m_tvalid=0 next cycle, elem_count=0, next s beat restarts at element 0.
- Async reset: rst asserted mid-beat between clock edges -> all outputs reach reset values before the next edge, and there is no tlast or pkt_done.
